seg_display_scan: RTL and testbench

- Downstream consumer of the CPU's observable outputs (Leddata, Count_all, Count_branch, Count_jmp).
- Time-multiplexes one selected 32-bit word onto an 8-digit common-anode seven-segment display as 8 hex nibbles.
- Snapshots the selected word once per frame so a displayed frame never mixes two values.
- Sits between the MIPS_CPU top outputs and the board display pins.

---
 rtl/seg_display_scan.sv | 140 ++++++++++++++
 tb/tb_seg_display_scan.sv | 135 +++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// seg_display_scan: time-multiplexes one selected 32-bit CPU word onto an
// 8-digit common-anode seven-segment display, one hex nibble per digit.
// The selected word is snapshotted once per frame so a frame never mixes values.
//
// Ports:
//   clk          system clock
//   clr          synchronous active-high reset
//   disp_sel     source select: 0=leddata 1=count_all 2=count_branch 3=count_jmp
//   leddata      CPU display word
//   count_all    total cycle counter
//   count_branch taken-branch counter
//   count_jmp    jump counter
//   an           digit enables, active-low, an[0] = rightmost digit = nibble [3:0]
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low (lit on digit 0 when a counter is shown)
//
// Parameter SCAN_DIV: clk cycles each digit is driven (>= 2).
// Optional macro SEG_LEADING_ZERO_BLANK_EN: blank leading-zero digits (digit 0 never blanked).
module seg_display_scan #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  disp_sel,
  input  logic [31:0] leddata,
  input  logic [31:0] count_all,
  input  logic [31:0] count_branch,
  input  logic [31:0] count_jmp,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       dig_idx_q, dig_idx_d;
  logic [31:0]      snap_q, snap_d;
  logic [1:0]       snap_sel_q, snap_sel_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic [31:0]      sel_word;
  logic [3:0]       nibble;
  logic [4:0]       bit_base;

  // Active-low hex glyphs for segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Source word mux.
  always_comb begin
    sel_word = leddata;
    case (disp_sel)
      2'd1:    sel_word = count_all;
      2'd2:    sel_word = count_branch;
      2'd3:    sel_word = count_jmp;
      default: sel_word = leddata;
    endcase
  end

  // Next-state: divider, digit index, frame snapshot and output pipeline.
  always_comb begin
    div_cnt_d  = div_cnt_q + CNT_W'(1);
    dig_idx_d  = dig_idx_q;
    snap_d     = snap_q;
    snap_sel_d = snap_sel_q;

    if (div_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      div_cnt_d = '0;
      dig_idx_d = dig_idx_q + 3'd1;
    end

    // Frame start: capture the selected word for the whole upcoming frame.
    if ((dig_idx_q == 3'd0) && (div_cnt_q == '0)) begin
      snap_d     = sel_word;
      snap_sel_d = disp_sel;
    end

    // Outputs use the pre-edge snapshot, so a new snapshot shows one cycle later.
    bit_base = {dig_idx_q, 2'b00};
    nibble   = snap_q[bit_base +: 4];
    an_d     = ~(8'b1 << dig_idx_q);
    seg_d    = hex_decode(nibble);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Blank a digit when it and every higher nibble are zero.
    if ((dig_idx_q != 3'd0) && ((snap_q >> bit_base) == 32'd0)) begin
      seg_d = 7'h7F;
    end
`endif
    dp_d = ~((dig_idx_q == 3'd0) && (snap_sel_q != 2'd0));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt_q  <= '0;
      dig_idx_q  <= 3'd0;
      snap_q     <= 32'd0;
      snap_sel_q <= 2'd0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      div_cnt_q  <= div_cnt_d;
      dig_idx_q  <= dig_idx_d;
      snap_q     <= snap_d;
      snap_sel_q <= snap_sel_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with SCAN_DIV=4 (32-cycle frames).
module tb_seg_display_scan;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  disp_sel;
  logic [31:0] leddata, count_all, count_branch, count_jmp;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vectors = 0;
  int miscompares = 0;

  // Per-digit expected glyphs, packed {digit7, ..., digit0}.
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [7:0][6:0] T_0123 = {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  localparam logic [7:0][6:0] T_A    = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08};
  localparam logic [7:0][6:0] T_100  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40};
`else
  localparam logic [7:0][6:0] T_0123 = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  localparam logic [7:0][6:0] T_A    = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08};
  localparam logic [7:0][6:0] T_100  = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40};
`endif
  localparam logic [7:0][6:0] T_F    = {8{7'h0E}};

  seg_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk          (clk),
    .clr          (clr),
    .disp_sel     (disp_sel),
    .leddata      (leddata),
    .count_all    (count_all),
    .count_branch (count_branch),
    .count_jmp    (count_jmp),
    .an           (an),
    .seg          (seg),
    .dp           (dp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] ea, input logic [6:0] es, input logic ed);
    vectors++;
    assert (an === ea) else begin
      miscompares++;
      $error("FAIL %s an: got %h want %h", tag, an, ea);
    end
    vectors++;
    assert (seg === es) else begin
      miscompares++;
      $error("FAIL %s seg: got %h want %h", tag, seg, es);
    end
    vectors++;
    assert (dp === ed) else begin
      miscompares++;
      $error("FAIL %s dp: got %b want %b", tag, dp, ed);
    end
  endtask

  // Steps through frame cycles j0..j1 (j=0 is the snapshot edge, which still
  // shows digit 0 of the previous snapshot: first_seg/first_dp).
  task automatic run_digits(input string tag, input int j0, input int j1,
                            input logic [7:0][6:0] tbl, input logic [6:0] first_seg,
                            input logic first_dp, input logic dp0);
    for (int j = j0; j <= j1; j++) begin
      int d;
      logic [7:0] ea;
      logic [6:0] es;
      logic       ed;
      tick();
      d  = j / int'(SCAN_DIV);
      ea = ~(8'b1 << d);
      es = (j == 0) ? first_seg : tbl[d];
      ed = (j == 0) ? first_dp : ((d == 0) ? dp0 : 1'b1);
      check($sformatf("%s_j%0d", tag, j), ea, es, ed);
    end
  endtask

  initial begin
    clr          = 1'b1;
    disp_sel     = 2'd0;
    leddata      = 32'h01234567;
    count_all    = 32'h00001111;
    count_branch = 32'h0;
    count_jmp    = 32'h0;

    // Reset held for three edges.
    repeat (3) begin
      tick();
      check("reset", 8'hFF, 7'h7F, 1'b1);
    end
    clr = 1'b0;

    // Hex scan; first edge shows digit 0 of the reset snapshot (zero).
    run_digits("scan", 0, 31, T_0123, 7'h40, 1'b1, 1'b1);

    // Frame-coherence: change leddata while digit 3 is active.
    run_digits("coh_a", 0, 12, T_0123, 7'h78, 1'b1, 1'b1);
    leddata = 32'hFFFFFFFF;
    run_digits("coh_b", 13, 31, T_0123, 7'h78, 1'b1, 1'b1);

    // All-F frame; switch source mid-frame.
    run_digits("allf_a", 0, 9, T_F, 7'h78, 1'b1, 1'b1);
    disp_sel     = 2'd2;
    count_branch = 32'h0000000A;
    run_digits("allf_b", 10, 31, T_F, 7'h78, 1'b1, 1'b1);

    // count_branch frame: dp lit on digit 0 once the new snap_sel takes effect.
    run_digits("sel", 0, 31, T_A, 7'h0E, 1'b1, 1'b0);

    // Run to dig_idx=5, div_cnt=2, then reset for one cycle.
    run_digits("pre_rst", 0, 21, T_A, 7'h08, 1'b0, 1'b0);
    clr      = 1'b1;
    disp_sel = 2'd0;
    leddata  = 32'h00000100;
    tick();
    check("rst_mid", 8'hFF, 7'h7F, 1'b1);
    clr = 1'b0;

    // Restart with a fresh snapshot; also exercises leading-zero handling.
    run_digits("lz", 0, 31, T_100, 7'h40, 1'b1, 1'b1);
    run_digits("lz2", 0, 3, T_100, 7'h40, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
